// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: records retired instructions into a small FIFO with
// cycle/retire stamps, optional filtering and a drop-newest or overwrite-oldest full policy.
module commit_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 32,
  parameter int OVERWRITE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       commit_valid,
  input  logic [XLEN-1:0]            commit_pc,
  input  logic                       commit_reg_write,
  input  logic [4:0]                 commit_rd,
  input  logic [XLEN-1:0]            commit_wdata,
  input  logic                       commit_mem_read,
  input  logic                       commit_mem_write,
  input  logic [XLEN-1:0]            commit_addr,
  input  logic [XLEN-1:0]            commit_mdata,
  input  logic                       filter_en,
  input  logic                       freeze,
  input  logic                       clear,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [CNT_W-1:0]           out_inum,
  output logic [CNT_W-1:0]           out_cycle,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_wdata,
  output logic [XLEN-1:0]            out_addr,
  output logic [XLEN-1:0]            out_mdata,
  output logic [4:0]                 out_rd,
  output logic [2:0]                 out_flags,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           drop_count,
  output logic [CNT_W-1:0]           inst_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [XLEN-1:0]  pcMem    [DEPTH];
  logic [XLEN-1:0]  wdataMem [DEPTH];
  logic [XLEN-1:0]  addrMem  [DEPTH];
  logic [XLEN-1:0]  mdataMem [DEPTH];
  logic [CNT_W-1:0] inumMem  [DEPTH];
  logic [CNT_W-1:0] cycleMem [DEPTH];
  logic [4:0]       rdMem    [DEPTH];
  logic [2:0]       flagsMem [DEPTH];

  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [LVL_W-1:0] count;
  logic [CNT_W-1:0] cycleCnt, instCnt, dropCnt;

  logic recordable, isFull, doPop, doWrite, overwriteHead, dropEntry;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    recordable    = commit_valid && !freeze && !clear &&
                    (!filter_en || commit_reg_write || commit_mem_write);
    isFull        = (count == FULL_LVL);
    doPop         = (count != '0) && out_ready && !clear;
    doWrite       = recordable;
    overwriteHead = 1'b0;
    dropEntry     = 1'b0;
    // A simultaneous pop frees a slot, so only a pop-less push into a full buffer loses data.
    if (recordable && isFull && !doPop) begin
      dropEntry = 1'b1;
      if (OVERWRITE != 0) overwriteHead = 1'b1;
      else                doWrite       = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      cycleCnt <= '0;
      instCnt  <= '0;
      dropCnt  <= '0;
    end else if (clear) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      cycleCnt <= '0;
      instCnt  <= '0;
      dropCnt  <= '0;
    end else begin
      cycleCnt <= cycleCnt + CNT_W'(1);
      if (commit_valid) instCnt <= instCnt + CNT_W'(1);
      if (dropEntry && (dropCnt != '1)) dropCnt <= dropCnt + CNT_W'(1);
      if (doWrite) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop || overwriteHead) rdPtr <= rdPtr + PTR_W'(1);
      if (doWrite && !doPop && !overwriteHead) count <= count + LVL_W'(1);
      else if (doPop && !doWrite)              count <= count - LVL_W'(1);
    end
  end

  // NOTE: the entry storage has no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      pcMem[wrPtr]    <= commit_pc;
      wdataMem[wrPtr] <= commit_wdata;
      addrMem[wrPtr]  <= commit_addr;
      mdataMem[wrPtr] <= commit_mdata;
      inumMem[wrPtr]  <= instCnt;
      cycleMem[wrPtr] <= cycleCnt;
      rdMem[wrPtr]    <= commit_rd;
      flagsMem[wrPtr] <= {commit_mem_write, commit_mem_read, commit_reg_write};
    end
  end

  assign out_valid  = (count != '0);
  assign out_inum   = inumMem[rdPtr];
  assign out_cycle  = cycleMem[rdPtr];
  assign out_pc     = pcMem[rdPtr];
  assign out_wdata  = wdataMem[rdPtr];
  assign out_addr   = addrMem[rdPtr];
  assign out_mdata  = mdataMem[rdPtr];
  assign out_rd     = rdMem[rdPtr];
  assign out_flags  = flagsMem[rdPtr];
  assign level      = count;
  assign drop_count = dropCnt;
  assign inst_count = instCnt;

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: width of PC, write data, memory address and memory data fields.
REQ-002 The block SHALL have parameter DEPTH, default 16: entry count, a power of two and at least 2.
REQ-003 The block SHALL have parameter CNT_W, default 32: width of the instruction, cycle and drop counters.
REQ-004 The block SHALL have parameter OVERWRITE, default 0: full-buffer policy (0 = drop newest, 1 = overwrite oldest).
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (sole clock); rst input 1 (asynchronous, active-high).
REQ-006 The block SHALL have these inputs:
- commit_valid input 1: one instruction retires this cycle.
- commit_pc input XLEN: PC of the retiring instruction.
- commit_reg_write input 1: register write flag.
- commit_rd input 5: destination register.
- commit_wdata input XLEN: register write data.
- commit_mem_read input 1: load flag.
- commit_mem_write input 1: store flag.
- commit_addr input XLEN: memory address.
- commit_mdata input XLEN: store data.
- filter_en input 1: record only commits with reg_write or mem_write set.
- freeze input 1: suppress recording.
- clear input 1: synchronous flush.
- out_ready input 1: consumer accepts the head entry.
REQ-007 The block SHALL have these outputs:
- out_valid output 1: buffer non-empty.
- out_inum output CNT_W: retire number.
- out_cycle output CNT_W: cycle stamp.
- out_pc, out_wdata, out_addr, out_mdata output XLEN: head entry fields.
- out_rd output 5: head entry destination register.
- out_flags output 3: {mem_write, mem_read, reg_write}.
- level output $clog2(DEPTH)+1: occupancy.
- drop_count output CNT_W: lost entries.
- inst_count output CNT_W: retired instructions.

Function
REQ-008 cycle_cnt SHALL increment by 1 every clk edge out of reset and wrap modulo 2^CNT_W.
REQ-009 inst_count SHALL increment by 1 on every clk edge with commit_valid=1, regardless of filter_en or freeze, and wrap modulo 2^CNT_W.
REQ-010 A commit SHALL be recordable when commit_valid=1, freeze=0, clear=0, and (filter_en=0 or commit_reg_write=1 or commit_mem_write=1).
REQ-011 A recorded entry SHALL store: inum = inst_count before the increment, cycle = cycle_cnt before the increment, and all commit_* fields.
REQ-012 out_* SHALL present the oldest entry whenever out_valid=1; a pop SHALL occur on a clk edge with out_valid=1 and out_ready=1.
REQ-013 A push into an empty buffer SHALL raise out_valid on the following cycle (1-cycle latency).
REQ-014 out_ready while empty SHALL have no effect.
REQ-015 A push and a pop on the same edge SHALL leave level unchanged and SHALL never drop, including when the buffer is full.
REQ-016 With OVERWRITE=0, a push without a pop while level=DEPTH SHALL discard the new entry and increment drop_count.
REQ-017 With OVERWRITE=1, a push without a pop while level=DEPTH SHALL replace the oldest entry, advance the head, keep level=DEPTH, and increment drop_count.
REQ-018 drop_count SHALL saturate at 2^CNT_W-1.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; level SHALL equal DEPTH when full and 0 when empty.
REQ-020 clear=1 SHALL, on the clk edge, empty the buffer and zero inst_count, cycle_cnt and drop_count; any concurrent commit or pop SHALL be ignored.
REQ-021 Non-recordable commits (freeze or filtered) SHALL NOT increment drop_count.

Reset
REQ-022 While rst=1 (asynchronous assertion), the block SHALL hold: pointers=0, level=0, out_valid=0, inst_count=0, cycle_cnt=0, drop_count=0.
REQ-023 Storage contents SHALL need no reset, and out_* data fields SHALL be don't-care while out_valid=0.
REQ-024 rst asserted mid-operation SHALL discard all entries immediately.
REQ-025 The first cycle stamp after rst deasserts SHALL be 0.

Verification (DEPTH=4, CNT_W=32)
REQ-026 Reset release, then commit_valid at cycles 0,1,2 (PCs 0x0,0x4,0x8, out_ready=0) SHALL yield level=3; pops SHALL return inum 0,1,2 and cycle 0,1,2 in order.
REQ-027 filter_en=1 with commits {branch, reg_write rd=5 wdata=0x11, store addr=0x100 mdata=0xAB} SHALL record 2 entries with inum 1,2 and flags 001,100; inst_count=3.
REQ-028 OVERWRITE=0 with 6 commits and no pops SHALL yield level=4, drop_count=2, and a head inum of 0.
REQ-029 OVERWRITE=1 with 6 commits and no pops SHALL yield level=4, drop_count=2, and a head inum of 2.
REQ-030 With the buffer full and a simultaneous commit and pop every cycle for 8 cycles, the bench SHALL observe level=4 constant, drop_count=0, and popped inum strictly consecutive.
REQ-031 Asserting clear (or rst) with level=3 SHALL yield, next edge, out_valid=0, level=0, and inst_count=0; a commit on the clear edge SHALL be lost.
